nf_ram_bp: RTL and testbench
============================

# nf_ram_bp

Parametrised single-port data RAM with byte-enable writes, a registered read pipeline of configurable latency, out-of-range detection and an optional post-reset zero-fill sequencer. It sits between the nanoFOX core's load/store path or bus matrix and on-chip memory, and replaces the combinational-read word RAM. Every accepted request is acknowledged a fixed number of cycles later, so masters can issue one request per cycle.

## Interface
- `depth`, 64: memory size in words.
- `data_w`, 32: word width in bits; must be a multiple of 8, so there are NB = data_w/8 byte lanes.
- `rd_lat`, 1: request-to-ack latency in cycles; legal values are 1 and 2.
- `init_zero`, 1: 1 = zero-fill all words after reset; 0 = no fill.

- `clk`  in  1  clock; all activity is on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `req`  in  1  request valid, sampled each cycle.
- `we`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr`  in  32  byte address.
- `be`  in  NB  byte-lane write enables; ignored for reads.
- `wd`  in  data_w  write data.
- `busy`  out  1  high while the block is in reset or zero-filling; requests are not accepted.
- `ack`  out  1  one-cycle pulse marking completion of an accepted request.
- `err`  out  1  valid with `ack`: the request addressed a word outside the memory.
- `rd`  out  data_w  read data, valid with `ack` on reads.

## Operation
- **Word index:** `widx = addr >> log2(NB)`. The low log2(NB) address bits are ignored; there is no misalignment error.
- **Range check:** a request is out of range when `widx >= depth`, compared at full 32-bit width with no wrap.
- **Acceptance:** a request is accepted when `req && !busy && resetn`.
- **Write, in range:** for each lane i with `be[i]=1`, byte i of word `widx` takes `wd[8i+7:8i]` at the accepting edge. Lanes with `be[i]=0` are unchanged. A write with `be=0` is acked with no change.
- **Read, in range:** `ram[widx]` is captured at the accepting edge (data as it was before that edge) and then passed through the pipeline.
- **Out of range:** no memory write occurs; the response is acked with `err=1` and `rd=0`.
- **Writes:** `rd` is 0 on write acks.
- **Pipeline:** an `rd_lat`-stage shift of {valid, err, data}. Accepted requests are never dropped and there is no backpressure.
- **Zero-fill FSM**, states INIT, FILL and READY:
  - `resetn` low forces INIT and sets the fill counter to 0.
  - INIT goes to FILL on the first edge where `resetn` is high if `init_zero=1`, otherwise to READY.
  - FILL writes 0 to word `cnt` every cycle and increments `cnt`. After writing word `depth-1` it goes to READY.
  - `busy` is 1 in INIT and FILL, and 0 in READY.
- Memory contents are not reset by `resetn`; only the fill sequence clears them.

## Timing
- **Reset values**, held while `resetn`=0: `ack`=0, `err`=0, `rd`=0, `busy`=1. All pipeline valid bits are cleared.
- **Reset mid-operation:** in-flight requests are discarded and never acked. A request presented in the same cycle as `resetn`=0 is ignored.
- **Fill duration:** with `init_zero=1`, `busy` stays high for exactly `depth` cycles after the first `resetn`=1 edge. With `init_zero=0`, `busy` falls after one cycle.
- **Ack latency:** for a request accepted at edge N, `ack`, `err` and `rd` are valid in the cycle following edge N+`rd_lat`-1. For `rd_lat`=1 that is the cycle immediately after acceptance.
- **Throughput:** one request per cycle. Back-to-back requests produce back-to-back acks in order.
- **Write then read, same word, consecutive cycles:** the read returns the newly written data.
- **Read accepted at the same edge as a write to the same word:** impossible, since there is a single port.
- **Read data path:** `rd` is driven only from pipeline registers, never combinationally from `addr`.

## Test plan
1. **Zero-fill:** release reset with `depth`=64 and `init_zero`=1. Expect `busy`=1 for 64 cycles, then 0. Read words 0, 31 and 63; each acks with `rd`=0x00000000 and `err`=0.
2. **Byte-enable merge:**
   - Write 0xAABBCCDD to addr 0x10 with `be`=0xF.
   - Write 0x11223344 to addr 0x10 with `be`=0x5.
   - Read addr 0x10: expect 0xAA22CC44.
   - Read addr 0x13: expect the same word.
3. **Latency and throughput:** issue 4 consecutive reads of words 0 to 3, preloaded with 1, 2, 3 and 4.
   - `rd_lat`=1: acks on 4 consecutive cycles starting 1 cycle after the first request, with `rd` = 1, 2, 3, 4.
   - `rd_lat`=2: the same sequence shifted one cycle later.
4. **Out of range:**
   - Write 0xDEADBEEF to addr 0x100 (word 64): ack with `err`=1 and no memory change.
   - Read addr 0xFFFFFFFC: ack with `err`=1 and `rd`=0.
   - Read word 0: unchanged.
5. **Busy gating:** assert `req` during FILL. Expect no ack and no write; the fill still leaves all words at 0.
6. **Reset mid-operation:** accept a read with `rd_lat`=2, then pull `resetn` low the next cycle. Expect no ack for that read, `ack`=`err`=`rd`=0 and `busy`=1, followed by a full new fill sequence.

Source files
------------

// File: rtl/nf_ram_bp.sv
// Single-port data RAM with byte-enable writes, a 1- or 2-stage registered read
// pipeline, out-of-range flagging and an optional post-reset zero-fill sequencer.
module nf_ram_bp #(
    parameter int unsigned depth     = 64,
    parameter int unsigned data_w    = 32,
    parameter int unsigned rd_lat    = 1,
    parameter int unsigned init_zero = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [data_w/8-1:0]   be,
    input  logic [data_w-1:0]     wd,
    output logic                  busy,
    output logic                  ack,
    output logic                  err,
    output logic [data_w-1:0]     rd
);

    localparam int unsigned NB = data_w / 8;
    localparam int unsigned LB = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned NS = (rd_lat >= 2) ? 2 : 1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FILL,
        ST_READY
    } state_t;

    typedef struct packed {
        logic              vld;
        logic              err;
        logic [data_w-1:0] dat;
    } stage_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    stage_t            pipe_q [NS];
    stage_t            pipe_d [NS];
    logic [data_w-1:0] mem_q [depth];

    logic [31:0]       widx_c;
    logic [AW-1:0]     row_c;
    logic              in_range_c;
    logic              acc_c;
    logic              fill_c;
    logic              mem_we_c;
    logic [AW-1:0]     mem_row_c;
    logic [data_w-1:0] mem_wd_c;
    logic [NB-1:0]     mem_be_c;

    // Request decode; the range check uses the full 32-bit word index.
    always_comb begin
        widx_c     = addr >> LB;
        row_c      = widx_c[AW-1:0];
        in_range_c = (widx_c < 32'(depth));
        acc_c      = req && !busy_q && resetn;
    end

    // Zero-fill sequencer: INIT -> (FILL ->) READY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_c  = 1'b0;
        case (state_q)
            ST_INIT: begin
                cnt_d   = '0;
                state_d = (init_zero != 0) ? ST_FILL : ST_READY;
            end
            ST_FILL: begin
                fill_c = resetn;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(depth - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
        busy_d = (state_d != ST_READY);
    end

    // Single write port shared by the fill sequencer and accepted writes.
    always_comb begin
        mem_we_c  = 1'b0;
        mem_row_c = row_c;
        mem_wd_c  = wd;
        mem_be_c  = be;
        if (fill_c) begin
            mem_we_c  = 1'b1;
            mem_row_c = cnt_q;
            mem_wd_c  = '0;
            mem_be_c  = '1;
        end else if (acc_c && we && in_range_c) begin
            mem_we_c = 1'b1;
        end
    end

    // Response pipeline; stage 0 captures the pre-edge word on reads.
    always_comb begin
        pipe_d[0].vld = acc_c;
        pipe_d[0].err = acc_c && !in_range_c;
        pipe_d[0].dat = (acc_c && !we && in_range_c) ? mem_q[row_c] : '0;
        for (int i = 1; i < NS; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            for (int i = 0; i < NS; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            for (int i = 0; i < NS; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Storage is deliberately not reset; only the fill sequence clears it.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be_c[b]) begin
                    mem_q[mem_row_c][8*b +: 8] <= mem_wd_c[8*b +: 8];
                end
            end
        end
    end

    assign busy = busy_q;
    assign ack  = pipe_q[NS-1].vld;
    assign err  = pipe_q[NS-1].err;
    assign rd   = pipe_q[NS-1].dat;

endmodule

// File: tb/tb_nf_ram_bp.sv
// Scoreboard bench for nf_ram_bp: one instance per read latency, fed identical stimulus.
module tb_nf_ram_bp;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        resetn, req, we;
    logic [31:0] addr, wd;
    logic [3:0]  be;
    logic        busy1, ack1, err1;
    logic [31:0] rd1;
    logic        busy2, ack2, err2;
    logic [31:0] rd2;

    always #5 clk = ~clk;

    nf_ram_bp #(.depth(DEPTH), .data_w(32), .rd_lat(1), .init_zero(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .be(be), .wd(wd),
        .busy(busy1), .ack(ack1), .err(err1), .rd(rd1)
    );

    nf_ram_bp #(.depth(DEPTH), .data_w(32), .rd_lat(2), .init_zero(1)) u_dut2 (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .be(be), .wd(wd),
        .busy(busy2), .ack(ack2), .err(err2), .rd(rd2)
    );

    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] mdl [DEPTH];
    int unsigned cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic        hit1, hit2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every cycle: an ack must appear exactly when the oldest expectation falls due.
    always @(negedge clk) begin
        if (mon_en) begin
            hit1 = (q1.size() != 0) && (q1[0].due == cyc);
            chk("ack_l1", 32'(ack1), 32'(hit1));
            if (hit1) begin
                chk("err_l1", 32'(err1), 32'(q1[0].err));
                chk("rd_l1", rd1, q1[0].rd);
                q1.delete(0);
            end
            hit2 = (q2.size() != 0) && (q2[0].due == cyc);
            chk("ack_l2", 32'(ack2), 32'(hit2));
            if (hit2) begin
                chk("err_l2", 32'(err2), 32'(q2[0].err));
                chk("rd_l2", rd2, q2[0].rd);
                q2.delete(0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        int unsigned wi;
        exp_t        e;
        wi    = a >> 2;
        e.err = (wi >= DEPTH);
        e.rd  = '0;
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) mdl[wi][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                e.rd = mdl[wi];
            end
        end
        req = 1'b1; we = w; addr = a; be = b; wd = d;
        e.due = cyc + 1;
        q1.push_back(e);
        e.due = cyc + 2;
        q2.push_back(e);
        step();
    endtask

    task automatic idle();
        req = 1'b0;
        we  = 1'b0;
        step();
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && (q1.size() + q2.size()) != 0; k++) idle();
        chk("drain", 32'(q1.size() + q2.size()), 32'd0);
    endtask

    // Reset, check reset values, then time the fill; optionally hammer writes during it.
    task automatic reset_and_fill(input bit poke);
        req = 1'b0;
        resetn = 1'b0;
        q1.delete();
        q2.delete();
        step();
        step();
        chk("rst_ack", 32'({ack1, ack2}), 32'd0);
        chk("rst_err", 32'({err1, err2}), 32'd0);
        chk("rst_rd1", rd1, 32'd0);
        chk("rst_rd2", rd2, 32'd0);
        chk("rst_busy", 32'({busy1, busy2}), 32'd3);
        resetn = 1'b1;
        for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("busy_fill", 32'({busy1, busy2}), 32'd3);
            if (poke) begin
                req = 1'b1; we = 1'b1; addr = 32'h14; be = 4'hF; wd = $urandom;
            end
        end
        step();
        req = 1'b0;
        chk("busy_done", 32'({busy1, busy2}), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wd = '0;
        step();
        step();
        mon_en = 1'b1;

        reset_and_fill(1'b0);
        issue(1'b0, 32'h00, 4'h0, 32'h0);
        issue(1'b0, 32'h7C, 4'h0, 32'h0);
        issue(1'b0, 32'hFC, 4'h0, 32'h0);
        drain();

        issue(1'b1, 32'h10, 4'hF, 32'hAABBCCDD);
        issue(1'b1, 32'h10, 4'h5, 32'h11223344);
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        issue(1'b0, 32'h13, 4'h0, 32'h0);
        drain();

        for (int i = 0; i < 4; i++) issue(1'b1, 32'(4 * i), 4'hF, 32'(i + 1));
        idle();
        for (int i = 0; i < 4; i++) issue(1'b0, 32'(4 * i), 4'h0, 32'h0);
        drain();

        issue(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 32'hFFFFFFFC, 4'h0, 32'h0);
        issue(1'b0, 32'h00, 4'h0, 32'h0);
        issue(1'b1, 32'h08, 4'h0, 32'hFFFFFFFF);
        issue(1'b0, 32'h08, 4'h0, 32'h0);
        issue(1'b1, 32'hFC, 4'hF, 32'h5A5AA5A5);
        issue(1'b0, 32'hFC, 4'h0, 32'h0);
        issue(1'b0, 32'h100, 4'h0, 32'h0);
        drain();

        reset_and_fill(1'b1);
        issue(1'b0, 32'h14, 4'h0, 32'h0);
        issue(1'b0, 32'h00, 4'h0, 32'h0);
        issue(1'b0, 32'hFC, 4'h0, 32'h0);
        drain();

        issue(1'b1, 32'h08, 4'hF, 32'h00000077);
        drain();
        issue(1'b0, 32'h08, 4'h0, 32'h0);
        reset_and_fill(1'b0);
        issue(1'b0, 32'h08, 4'h0, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
